// File: rtl/packer_pkg.sv
// Shared definitions for the narrow-to-wide packer: default geometry,
// counter-width helper, lane index type and the fill-state encoding.
package packer_pkg;

    localparam int unsigned IN_W_DEF  = 8;
    localparam int unsigned LANES_DEF = 4;

    // Width of the lane counter; the counter only ever holds 0..lanes-1.
    function automatic int unsigned cnt_w(input int unsigned lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

    typedef logic [cnt_w(LANES_DEF)-1:0] lane_idx_t;

    // EMPTY: no beats held; FILL: partial word held;
    // FLUSH_WAIT: partial word must be emitted once the output frees up.
    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_FILL       = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } pack_state_e;

endpackage

// File: rtl/packer_out_reg.sv
// Output holding register for the packer: loads a word (data/keep/count),
// holds it stable while the consumer stalls, drops valid once taken.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load                  capture load_* this edge (only asserted when out_free)
//   load_data/keep/count  word to present downstream
//   out_ready             consumer takes the current word
//   out_valid/data/keep/count  registered word towards consumer
//   out_free              register may accept a new word this cycle
module packer_out_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned KEEP_W  = 4,
    parameter int unsigned COUNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [KEEP_W-1:0]  load_keep,
    input  logic [COUNT_W-1:0] load_count,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [KEEP_W-1:0]  out_keep,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_free
);

    // A word leaving in the same cycle frees the slot for a new one.
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/narrow_to_wide_packer.sv
// Packs LANES beats of IN_W bits into one IN_W*LANES word with valid/ready
// on both sides, selectable lane order and a flush that emits a partial
// word with a lane-keep mask.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready/in_data   narrow beat input
//   flush             level request to emit the current partial word
//   out_valid/out_ready         wide word handshake
//   out_data          packed word
//   out_keep          one bit per lane holding a real beat
//   out_count         number of real beats in the word
module narrow_to_wide_packer
    import packer_pkg::*;
#(
    parameter int unsigned IN_W      = IN_W_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IN_W*LANES-1:0]        out_data,
    output logic [LANES-1:0]             out_keep,
    output logic [$clog2(LANES+1)-1:0]   out_count
);

    localparam int unsigned CNT_W = cnt_w(LANES);
    localparam int unsigned OUT_W = IN_W * LANES;
    localparam int unsigned OC_W  = $clog2(LANES + 1);

    pack_state_e      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [OUT_W-1:0] acc, acc_n, acc_with;
    logic [CNT_W-1:0] lane_idx;
    logic [OC_W-1:0]  filled;
    logic [LANES-1:0] keep_mask;
    logic             accept, complete, flush_req, out_free, load;

    // Holding a pending flush blocks input so the partial word is not extended.
    assign in_ready = (state != ST_FLUSH_WAIT)
                   && ((cnt != CNT_W'(LANES - 1)) || out_free);

    // Accumulator with this cycle's beat merged, plus fill bookkeeping.
    always_comb begin
        accept    = in_valid && in_ready;
        complete  = accept && (cnt == CNT_W'(LANES - 1));
        lane_idx  = MSB_FIRST ? (CNT_W'(LANES - 1) - cnt) : cnt;
        filled    = OC_W'(cnt) + OC_W'(accept);
        flush_req = flush || (state == ST_FLUSH_WAIT);
        acc_with  = acc;
        keep_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (accept && (lane_idx == CNT_W'(i)))
                acc_with[i*IN_W +: IN_W] = in_data;
            // MSB-first fills from the top lane down, LSB-first from lane 0 up.
            keep_mask[i] = MSB_FIRST ? (filled > OC_W'(LANES - 1 - i))
                                     : (OC_W'(i) < filled);
        end
    end

    // Next-state: complete word, flush (now or deferred), or keep filling.
    always_comb begin
        load    = 1'b0;
        cnt_n   = CNT_W'(filled);
        acc_n   = acc_with;
        state_n = (filled == '0) ? ST_EMPTY : ST_FILL;
        if (complete) begin
            // in_ready guarantees the output is free here.
            load    = 1'b1;
            cnt_n   = '0;
            acc_n   = '0;
            state_n = ST_EMPTY;
        end else if (flush_req && (filled != '0)) begin
            if (out_free) begin
                load    = 1'b1;
                cnt_n   = '0;
                acc_n   = '0;
                state_n = ST_EMPTY;
            end else begin
                state_n = ST_FLUSH_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
        end
    end

    packer_out_reg #(
        .DATA_W  (OUT_W),
        .KEEP_W  (LANES),
        .COUNT_W (OC_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (acc_with),
        .load_keep  (keep_mask),
        .load_count (filled),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_count  (out_count),
        .out_free   (out_free)
    );

endmodule

// File: tb/tb_narrow_to_wide_packer.sv
// Directed bench for narrow_to_wide_packer: an MSB-first and an LSB-first
// instance share all inputs; each vector checks in_ready before the edge
// and the output word after it.
module tb_narrow_to_wide_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, out_ready;
    logic [7:0]  in_data;
    logic        m_in_ready, l_in_ready, m_out_valid, l_out_valid;
    logic [31:0] m_out_data, l_out_data;
    logic [3:0]  m_out_keep, l_out_keep;
    logic [2:0]  m_out_count, l_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    narrow_to_wide_packer u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_data(m_out_data), .out_keep(m_out_keep),
        .out_count(m_out_count)
    );

    narrow_to_wide_packer #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_data(l_out_data), .out_keep(l_out_keep),
        .out_count(l_out_count)
    );

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        fl;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        logic [2:0]  exp_cnt;
        logic [31:0] exp_ldata;
        logic [3:0]  exp_lkeep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkn(logic iv, logic [7:0] d, logic fl, logic ordy, logic ir);
        vec_t v;
        v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy; v.exp_ir = ir;
        v.exp_ov = 1'b0; v.exp_data = '0; v.exp_keep = '0; v.exp_cnt = '0;
        v.exp_ldata = '0; v.exp_lkeep = '0;
        return v;
    endfunction

    function automatic vec_t mkw(logic iv, logic [7:0] d, logic fl, logic ordy, logic ir,
                                 logic [31:0] dat, logic [3:0] kp, logic [2:0] ct,
                                 logic [31:0] ldat, logic [3:0] lkp);
        vec_t v;
        v = mkn(iv, d, fl, ordy, ir);
        v.exp_ov = 1'b1; v.exp_data = dat; v.exp_keep = kp; v.exp_cnt = ct;
        v.exp_ldata = ldat; v.exp_lkeep = lkp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a rising edge; outputs are read 1 time unit later.
    task automatic run_vec(input vec_t v, input int idx);
        in_valid  = v.iv;
        in_data   = v.d;
        flush     = v.fl;
        out_ready = v.ordy;
        #1;
        chk($sformatf("v%0d msb in_ready", idx), 32'(m_in_ready), 32'(v.exp_ir));
        chk($sformatf("v%0d lsb in_ready", idx), 32'(l_in_ready), 32'(v.exp_ir));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d msb out_valid", idx), 32'(m_out_valid), 32'(v.exp_ov));
        chk($sformatf("v%0d lsb out_valid", idx), 32'(l_out_valid), 32'(v.exp_ov));
        if (v.exp_ov) begin
            chk($sformatf("v%0d msb out_data", idx),  m_out_data,         v.exp_data);
            chk($sformatf("v%0d msb out_keep", idx),  32'(m_out_keep),    32'(v.exp_keep));
            chk($sformatf("v%0d msb out_count", idx), 32'(m_out_count),   32'(v.exp_cnt));
            chk($sformatf("v%0d lsb out_data", idx),  l_out_data,         v.exp_ldata);
            chk($sformatf("v%0d lsb out_keep", idx),  32'(l_out_keep),    32'(v.exp_lkeep));
            chk($sformatf("v%0d lsb out_count", idx), 32'(l_out_count),   32'(v.exp_cnt));
        end
    endtask

    task automatic pulse_rst(input string name);
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({name, " out_valid"}, 32'(m_out_valid), 32'd0);
        chk({name, " lsb out_valid"}, 32'(l_out_valid), 32'd0);
        chk({name, " in_ready"}, 32'(m_in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset out_valid", 32'(m_out_valid), 32'd0);
        chk("reset out_data",  m_out_data,       32'd0);
        chk("reset out_keep",  32'(m_out_keep),  32'd0);
        chk("reset out_count", 32'(m_out_count), 32'd0);
        chk("reset in_ready",  32'(m_in_ready),  32'd1);

        // Back-to-back full word, both lane orders.
        vecs.push_back(mkn(1'b1, 8'h25, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h32, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h64, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkw(1'b1, 8'h85, 1'b0, 1'b1, 1'b1, 32'h25326485, 4'hF, 3'd4, 32'h85643225, 4'hF));
        vecs.push_back(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
        // Backpressure: word held, three more beats fit, eighth stalls.
        vecs.push_back(mkn(1'b1, 8'h01, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h02, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h03, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mkw(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 32'h05060708, 4'hF, 3'd4, 32'h08070605, 4'hF));
        vecs.push_back(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
        // Partial flush, then flush on an empty packer.
        vecs.push_back(mkn(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkn(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkw(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'hAABB0000, 4'b1100, 3'd2, 32'h0000BBAA, 4'b0011));
        vecs.push_back(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkn(1'b0, 8'h00, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
        // Flush together with the completing beat: exactly one word.
        vecs.push_back(mkn(1'b1, 8'h11, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h22, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h33, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkw(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 32'h11223344, 4'hF, 3'd4, 32'h44332211, 4'hF));
        vecs.push_back(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Flush while output busy: pending flush blocks input until emitted.
        vecs.delete();
        vecs.push_back(mkn(1'b1, 8'h01, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h02, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mkn(1'b1, 8'h03, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mkw(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF));
        vecs.push_back(mkw(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 32'h09000000, 4'b1000, 3'd1, 32'h00000009, 4'b0001));
        vecs.push_back(mkn(1'b1, 8'h0A, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mkw(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0A000000, 4'b1000, 3'd1, 32'h0000000A, 4'b0001));
        vecs.push_back(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
        foreach (vecs[i]) run_vec(vecs[i], 100 + i);

        // Reset mid-word discards partial data.
        run_vec(mkn(1'b1, 8'h01, 1'b0, 1'b1, 1'b1), 200);
        run_vec(mkn(1'b1, 8'h02, 1'b0, 1'b1, 1'b1), 201);
        pulse_rst("rst midword");
        run_vec(mkn(1'b1, 8'h0A, 1'b0, 1'b1, 1'b1), 202);
        run_vec(mkn(1'b1, 8'h0B, 1'b0, 1'b1, 1'b1), 203);
        run_vec(mkn(1'b1, 8'h0C, 1'b0, 1'b1, 1'b1), 204);
        run_vec(mkw(1'b1, 8'h0D, 1'b0, 1'b1, 1'b1, 32'h0A0B0C0D, 4'hF, 3'd4, 32'h0D0C0B0A, 4'hF), 205);
        run_vec(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1), 206);

        // Reset while a word is held drops it.
        run_vec(mkn(1'b1, 8'h01, 1'b0, 1'b0, 1'b1), 300);
        run_vec(mkn(1'b1, 8'h02, 1'b0, 1'b0, 1'b1), 301);
        run_vec(mkn(1'b1, 8'h03, 1'b0, 1'b0, 1'b1), 302);
        run_vec(mkw(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 3'd4, 32'h04030201, 4'hF), 303);
        pulse_rst("rst held word");
        run_vec(mkn(1'b0, 8'h00, 1'b0, 1'b1, 1'b1), 304);
        run_vec(mkn(1'b0, 8'h00, 1'b1, 1'b1, 1'b1), 305);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
